// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: an ALU result port and a load-result FIFO share one write port.
// Define WB_BYPASS_EN to let a load skip the empty FIFO when the ALU is idle.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic                     alu_thread_id,
  input  logic [3:0]               alu_addr,
  input  logic [15:0]              alu_data,
  output logic                     alu_stall,
  input  logic                     ld_valid,
  input  logic                     ld_thread_id,
  input  logic [3:0]               ld_addr,
  input  logic [15:0]              ld_data,
  output logic                     ld_ready,
  output logic                     w_en,
  output logic                     w_thread_id,
  output logic [3:0]               w_addr,
  output logic [15:0]              w_data,
  output logic [15:0]              pend_mask0,
  output logic [15:0]              pend_mask1,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int SW     = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic [DEPTH-1:0]  ent_vld;
  logic              mem_tid  [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic              fifo_ne, force_fifo, sel_fifo, sel_alu, bypass, push, pop;
  logic              vld_p0, tid_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              w_en_p1, w_tid_p1;
  logic [ADDR_W-1:0] w_addr_p1;
  logic [DATA_W-1:0] w_data_p1;

  // ---- stage p0: source selection ----
  always_comb begin
    fifo_ne    = (count != '0);
    force_fifo = fifo_ne && (starve_cnt == SW'(STARVE_MAX));
    sel_fifo   = fifo_ne && (force_fifo || !alu_valid);
    sel_alu    = alu_valid && !force_fifo;
`ifdef WB_BYPASS_EN
    bypass     = !fifo_ne && !alu_valid && ld_valid;
`else
    bypass     = 1'b0;
`endif
    ld_ready   = (count < CW'(DEPTH));
    alu_stall  = alu_valid && force_fifo;
    // A full FIFO refuses the push even when it pops on the same edge.
    push       = ld_valid && ld_ready && !bypass;
    pop        = sel_fifo;
  end

  always_comb begin
    vld_p0  = 1'b0;
    tid_p0  = 1'b0;
    addr_p0 = '0;
    data_p0 = '0;
    if (sel_fifo) begin
      vld_p0  = 1'b1;
      tid_p0  = mem_tid[rd_ptr];
      addr_p0 = mem_addr[rd_ptr];
      data_p0 = mem_data[rd_ptr];
    end else if (sel_alu) begin
      vld_p0  = 1'b1;
      tid_p0  = alu_thread_id;
      addr_p0 = alu_addr;
      data_p0 = alu_data;
    end else if (bypass) begin
      vld_p0  = 1'b1;
      tid_p0  = ld_thread_id;
      addr_p0 = ld_addr;
      data_p0 = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_tid[wr_ptr]  <= ld_thread_id;
      mem_addr[wr_ptr] <= ld_addr;
      mem_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ent_vld    <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (!fifo_ne || pop)
        starve_cnt <= '0;
      else if (sel_alu && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Pending masks come from the registered entry flags, so duplicates stay set until the last one pops.
  always_comb begin
    pend_mask0 = '0;
    pend_mask1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        if (mem_tid[i]) pend_mask1[mem_addr[i]] = 1'b1;
        else            pend_mask0[mem_addr[i]] = 1'b1;
      end
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_p1   <= 1'b0;
      w_tid_p1  <= 1'b0;
      w_addr_p1 <= '0;
      w_data_p1 <= '0;
    end else begin
      w_en_p1   <= vld_p0;
      w_tid_p1  <= tid_p0;
      w_addr_p1 <= addr_p0;
      w_data_p1 <= data_p0;
    end
  end

  assign w_en        = w_en_p1;
  assign w_thread_id = w_tid_p1;
  assign w_addr      = w_addr_p1;
  assign w_data      = w_data_p1;
  assign fifo_count  = count;

endmodule
